delay_line_ctrl: RTL

- Parametrised successor to the fixed-depth register delay line.
- Adds per-stage valid tracking, pipeline stall, flush, a runtime-selectable tap (0..DEPTH cycles of delay) and a live occupancy count.
- Used between pipeline stages that need to re-align operands by a variable number of cycles and must obey hazard stall/flush.

---
 rtl/delay_line_ctrl_if.sv | 25 ++
 rtl/delay_line_ctrl.sv | 85 ++++++++
 2 files changed

// File: rtl/delay_line_ctrl_if.sv
// Bundle for the delay line: upstream control/data in, selected tap and occupancy out.
// The master drives the pipeline inputs; the slave is the delay line itself.
interface delay_line_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 2
) ();
    logic             stall;
    logic             flush;
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic [SEL_W-1:0] delay_sel;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [SEL_W-1:0] occ;

    modport master (
        output stall, flush, din_valid, din, delay_sel,
        input  dout, dout_valid, occ
    );

    modport slave (
        input  stall, flush, din_valid, din, delay_sel,
        output dout, dout_valid, occ
    );
endinterface

// File: rtl/delay_line_ctrl.sv
// Variable-tap register delay line with per-stage valid bits, stall, flush and occupancy.
// Tap 0 bypasses the stages; tap k reads stage k-1, and taps beyond DEPTH clamp to DEPTH.
module delay_line_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    delay_line_ctrl_if.slave   bus
);
    generate
        if (DEPTH < 1 || DEPTH > 64 || (2 ** SEL_W) <= DEPTH) begin : g_bad_param
            $fatal(1, "delay_line_ctrl: DEPTH must be 1..64 and 2**SEL_W must exceed DEPTH");
        end
    endgenerate

    localparam logic [SEL_W-1:0] DEPTH_S = SEL_W'(DEPTH);

    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] s_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [SEL_W-1:0] occ_q;
    logic [SEL_W-1:0] occ_d;

    logic [SEL_W-1:0] sel_c;
    logic [WIDTH-1:0] dout_c;
    logic             dout_valid_c;

    // Flush wins over stall; a stalled or flushed cycle never captures din.
    always_comb begin
        s_d   = s_q;
        v_d   = v_q;
        occ_d = occ_q;
        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_d[i] = '0;
            end
            v_d   = '0;
            occ_d = '0;
        end else if (!bus.stall) begin
            s_d[0] = bus.din;
            v_d[0] = bus.din_valid;
            for (int i = 1; i < DEPTH; i++) begin
                s_d[i] = s_q[i-1];
                v_d[i] = v_q[i-1];
            end
            occ_d = occ_q + SEL_W'(bus.din_valid) - SEL_W'(v_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_q[i] <= '0;
            end
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                s_q[i] <= s_d[i];
            end
            v_q   <= v_d;
            occ_q <= occ_d;
        end
    end

    // Tap mux; the default covers delay_sel = 0, the only combinational din-to-dout path.
    always_comb begin
        sel_c        = (bus.delay_sel > DEPTH_S) ? DEPTH_S : bus.delay_sel;
        dout_c       = bus.din;
        dout_valid_c = bus.din_valid;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_c == SEL_W'(i + 1)) begin
                dout_c       = s_q[i];
                dout_valid_c = v_q[i];
            end
        end
    end

    assign bus.dout       = dout_c;
    assign bus.dout_valid = dout_valid_c;
    assign bus.occ        = occ_q;
endmodule
